muldiv_hilo: RTL
================

// Module: muldiv_hilo
// PURPOSE
//  EXE-stage HI/LO unit, downstream of the ID controller. Takes RHLWr/RHLSel_Wr/ALU2Op/RHLSel_Rd
//  (via ID/EXE) and performs MTHI/MTLO, MULT/MULTU and DIV/DIVU. Owns the HI/LO registers.
//  Multi-cycle ops assert Busy so the hazard unit stalls IF/ID/EXE; Flush aborts on exception/eret.
// PARAMETERS
//  MUL_LAT  4   multiply latency in cycles from accept to HI/LO update (2..8)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   synchronous reset, active-low
//  RHLWr      in   1   HI/LO write request from EXE-stage control
//  RHLSel_Wr  in   2   00 MTLO, 01 MTHI, 10 mult/div result, 11 reserved (ignored)
//  ALU2Op     in   2   00 MULTU, 01 MULT, 10 DIVU, 11 DIV (valid when RHLSel_Wr==10)
//  RHLSel_Rd  in   1   1 read HI, 0 read LO
//  Op1        in   32  rs operand (dividend / multiplicand / MTHI-MTLO data)
//  Op2        in   32  rt operand (divisor / multiplier)
//  Flush      in   1   abort in-flight op (exception, eret_flush)
//  Busy       out  1   multi-cycle op in flight; stall pipeline
//  RHLOut     out  32  HI or LO per RHLSel_Rd (combinational from registers)
// BEHAVIOUR
//  - Reset (rst==0 at posedge): HI=LO=0, state IDLE, Busy=0, counter=0, no write.
//  - States: IDLE, MUL, DIV. Busy = (state != IDLE), registered.
//  - Accept only in IDLE with RHLWr=1 and Flush=0. Requests while Busy are ignored;
//    hazard unit must hold the instruction in EXE.
//  - MTLO/MTHI: LO/HI <= Op1 at the accepting edge; state stays IDLE; Busy stays 0.
//  - Mult (RHLSel_Wr=10, ALU2Op[1]=0): latch Op1/Op2 and sign mode; go to MUL.
//    Product: 64-bit, signed for MULT, unsigned for MULTU. {HI,LO} written at edge MUL_LAT after
//    accept. Busy high for MUL_LAT-1 cycles, low the cycle after the write.
//  - Div (ALU2Op[1]=1): go to DIV; radix-2 restoring, one quotient bit per cycle, 32 iterations on
//    magnitudes plus 1 sign-fix cycle. LO=quotient, HI=remainder written at edge 33 after accept.
//    Signed: quotient negated iff Op1[31]^Op2[31]; remainder takes sign of Op1.
//    Divisor==0: op runs full 33 cycles, HI/LO NOT written (architecturally undefined).
//    0x80000000 / -1 (DIV): LO=0x80000000, HI=0 (two's-complement wrap, no trap).
//  - Width rules: magnitudes 32-bit unsigned, partial remainder 33-bit, product 64-bit.
//    Operands are latched at accept; Op1/Op2 changes during Busy have no effect.
//  - Flush: at any edge with Flush=1 the state returns to IDLE, Busy=0 next cycle, no HI/LO write.
//    Flush takes priority over a same-cycle accept and over a same-cycle completion write.
//  - Completion edge: the state returns to IDLE, so a new accept is possible in the next cycle.
//    No back-to-back accept on the completion edge itself.
//  - Reset mid-op: same as reset; partial results discarded.
//  - RHLOut reflects HI/LO after the write edge. The hazard unit stalls MFHI/MFLO while Busy.
// TESTING
//  - MTHI 0x12345678, then MTLO 0x9ABCDEF0 -> HI/LO updated one cycle each; Busy never high.
//    RHLSel_Rd selects correctly.
//  - MULT 0xFFFFFFFF*0x00000002 -> after MUL_LAT: HI=0xFFFFFFFF, LO=0xFFFFFFFE.
//    MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE.
//  - DIV -7/2 -> at cycle 33: LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
//    Busy high exactly 32 cycles.
//  - DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU x/0 -> HI/LO unchanged after 33 cycles.
//  - Start DIVU, assert Flush at cycle 10 -> Busy low next cycle, HI/LO unchanged.
//    A new MULT accepted the cycle after completes normally.
//  - Assert rst=0 mid-DIV -> HI=LO=0, Busy=0. A new request issued with Busy=1 is ignored.

Source files
------------

// File: rtl/muldiv_hilo.sv
// muldiv_hilo: EXE-stage HI/LO unit. Owns the HI/LO registers and runs MTHI/MTLO,
// MULT/MULTU (fixed-latency) and DIV/DIVU (radix-2 restoring, 32 iterations + sign fix).
module muldiv_hilo #(
  parameter int MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RHLWr,
  input  logic [1:0]  RHLSel_Wr,
  input  logic [1:0]  ALU2Op,
  input  logic        RHLSel_Rd,
  input  logic [31:0] Op1,
  input  logic [31:0] Op2,
  input  logic        Flush,
  output logic        Busy,
  output logic [31:0] RHLOut
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state, state_next;
  logic [31:0] hi, lo;
  logic [31:0] op_a, op_b;
  logic        signed_op;
  logic [5:0]  count;
  logic [31:0] rem, quot;
  logic        neg_q, neg_r;

  logic        accept, start_mul, start_div, mt_lo, mt_hi;
  logic        mul_done, div_done;
  logic [63:0] ext_a, ext_b, product;
  logic [32:0] shifted, trial;
  logic        ge;
  logic [31:0] rem_next, quot_next;
  logic [31:0] fixed_q, fixed_r;
  logic [31:0] mag_a, mag_b;

  // Request decode: only an idle, unflushed unit takes a new operation
  always_comb begin
    accept    = (state == IDLE) && RHLWr && !Flush;
    mt_lo     = accept && (RHLSel_Wr == 2'b00);
    mt_hi     = accept && (RHLSel_Wr == 2'b01);
    start_mul = accept && (RHLSel_Wr == 2'b10) && !ALU2Op[1];
    start_div = accept && (RHLSel_Wr == 2'b10) &&  ALU2Op[1];
    mul_done  = (state == MUL) && (count == 6'(MUL_LAT - 1));
    div_done  = (state == DIV) && (count == 6'd32);
    mag_a     = (ALU2Op[0] && Op1[31]) ? -Op1 : Op1;
    mag_b     = (ALU2Op[0] && Op2[31]) ? -Op2 : Op2;
  end

  // Arithmetic: 64-bit product (sign-extension selects MULT vs MULTU), one restoring
  // divide step on a 33-bit partial remainder, and the final sign correction
  always_comb begin
    ext_a     = {{32{signed_op & op_a[31]}}, op_a};
    ext_b     = {{32{signed_op & op_b[31]}}, op_b};
    product   = ext_a * ext_b;
    shifted   = {rem, quot[31]};
    trial     = shifted - {1'b0, op_b};
    ge        = ~trial[32];
    rem_next  = ge ? trial[31:0] : shifted[31:0];
    quot_next = {quot[30:0], ge};
    fixed_q   = neg_q ? -quot : quot;
    fixed_r   = neg_r ? -rem : rem;
  end

  // Next-state logic; Flush beats both a new accept and a completion
  always_comb begin
    state_next = state;
    if (Flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_mul)      state_next = MUL;
          else if (start_div) state_next = DIV;
        end
        MUL:     if (mul_done) state_next = IDLE;
        DIV:     if (div_done) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // State register; Busy rises the cycle after accept and drops once the op ends
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      Busy  <= 1'b0;
    end else begin
      state <= state_next;
      Busy  <= (state != IDLE) && (state_next != IDLE);
    end
  end

  // Datapath: operand latching, iteration and HI/LO writes
  always_ff @(posedge clk) begin
    if (!rst) begin
      hi        <= '0;
      lo        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      signed_op <= 1'b0;
      count     <= '0;
      rem       <= '0;
      quot      <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
    end else begin
      if (mt_lo) lo <= Op1;
      if (mt_hi) hi <= Op1;
      if (start_mul) begin
        op_a      <= Op1;
        op_b      <= Op2;
        signed_op <= ALU2Op[0];
        count     <= '0;
      end
      if (start_div) begin
        quot  <= mag_a;
        op_b  <= mag_b;
        rem   <= '0;
        neg_q <= ALU2Op[0] & (Op1[31] ^ Op2[31]);
        neg_r <= ALU2Op[0] & Op1[31];
        count <= '0;
      end
      if (state == MUL && !Flush) begin
        count <= count + 6'd1;
        if (mul_done) {hi, lo} <= product;
      end
      if (state == DIV && !Flush) begin
        count <= count + 6'd1;
        if (div_done) begin
          if (op_b != '0) begin
            lo <= fixed_q;
            hi <= fixed_r;
          end
        end else begin
          rem  <= rem_next;
          quot <= quot_next;
        end
      end
    end
  end

  assign RHLOut = RHLSel_Rd ? hi : lo;

endmodule
